// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_arbiter
// Brief    : Shares one single-port frame-buffer RAM between display reads
//            (always first), a host write FIFO and a full-buffer clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 3,
    parameter int DEPTH      = 28800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_full  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  c_two   = CNT_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_WAIT = 2'd1,
        ST_CLEAR    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
    logic [DATA_W-1:0] r_clr_color;
    logic [DATA_W-1:0] w_clr_color_next;
    logic              w_clr_wr;
    logic              w_clr_last;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [PTR_W-1:0]  w_next_ptr;
    logic              w_head_vld;
    logic              w_next_vld;
    logic              w_head_oor;
    logic              w_next_oor;
    logic              w_cand_vld;
    logic [ADDR_W-1:0] w_cand_addr;
    logic [DATA_W-1:0] w_cand_data;
    logic              w_fifo_wr;
    logic              w_push;
    logic [1:0]        w_pops;
    logic              w_wr_ready;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_p1;
    logic              r_rd_p2;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_clr_done;
    logic              r_wr_err;

    // wr_ready is gated by rst_n directly so it reads 0 for the whole reset.
    assign w_wr_ready = rst_n && (r_count != c_full) && (r_state == ST_IDLE);
    assign w_push     = wr_valid && w_wr_ready;

    // FIFO head selection: an out-of-range head is dropped without using the
    // slot, letting the entry behind it write in the same cycle.
    always_comb begin
        w_next_ptr  = r_rd_ptr + PTR_W'(1);
        w_head_vld  = (r_count != '0);
        w_next_vld  = (r_count >= c_two);
        w_head_oor  = w_head_vld && (r_fifo_addr[r_rd_ptr] >= c_depth);
        w_next_oor  = (r_fifo_addr[w_next_ptr] >= c_depth);
        w_cand_vld  = 1'b0;
        w_cand_addr = r_fifo_addr[r_rd_ptr];
        w_cand_data = r_fifo_data[r_rd_ptr];
        if (w_head_vld && !w_head_oor) begin
            w_cand_vld = 1'b1;
        end else if (w_head_oor && w_next_vld && !w_next_oor) begin
            w_cand_vld  = 1'b1;
            w_cand_addr = r_fifo_addr[w_next_ptr];
            w_cand_data = r_fifo_data[w_next_ptr];
        end
        w_fifo_wr = w_cand_vld && !disp_req && (r_state != ST_CLEAR);
        w_pops    = {1'b0, w_head_oor} + {1'b0, w_fifo_wr};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_clr_color <= w_clr_color_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clr_cnt_next   = r_clr_cnt;
        w_clr_color_next = r_clr_color;
        w_clr_wr         = 1'b0;
        w_clr_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_next     = ST_CLR_WAIT;
                    w_clr_color_next = clr_color;
                end
            end
            ST_CLR_WAIT: begin
                if (r_count == '0) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                if (!disp_req) begin
                    w_clr_wr = 1'b1;
                    if (r_clr_cnt == c_last) begin
                        w_clr_last     = 1'b1;
                        w_state_next   = ST_IDLE;
                        w_clr_cnt_next = '0;
                    end else begin
                        w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pops);
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pops);
            if (w_head_oor) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    // RAM port: display read, else clear write, else host write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (disp_req) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= disp_addr;
            r_mem_wdata <= '0;
        end else if (w_clr_wr) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_clr_cnt;
            r_mem_wdata <= r_clr_color;
        end else if (w_fifo_wr) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_cand_addr;
            r_mem_wdata <= w_cand_data;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end
    end

    // Request -> port -> RAM data -> disp_data: fixed three-cycle pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_p1      <= 1'b0;
            r_rd_p2      <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
            r_clr_done   <= 1'b0;
        end else begin
            r_rd_p1      <= disp_req;
            r_rd_p2      <= r_rd_p1;
            r_disp_valid <= r_rd_p2;
            if (r_rd_p2) begin
                r_disp_data <= mem_rdata;
            end
            r_clr_done   <= w_clr_last;
        end
    end

    assign wr_ready   = w_wr_ready;
    assign clr_busy   = (r_state == ST_CLR_WAIT) || (r_state == ST_CLEAR);
    assign clr_done   = r_clr_done;
    assign wr_err     = r_wr_err;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign disp_valid = r_disp_valid;
    assign disp_data  = r_disp_data;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_port_arbiter
// Brief    : Directed bench for fb_port_arbiter with a queue-based model of
//            the port schedule and a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 28800;

    logic              clk;
    logic              rst_n;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done), .wr_err(wr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port synchronous RAM.
    logic [DATA_W-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: pending host entries, clear mode, and the port op expected next.
    int q_a[$];
    int q_d[$];
    int dv_due[$];
    int dv_dat[$];
    int m_st;
    int m_cnt;
    int m_col;
    bit m_err;
    bit e_en, e_we, e_done;
    int e_addr, e_wd, e_dd;
    bit mon_on = 1'b0;

    always @(negedge clk) begin
        int  st;
        int  old_sz;
        bit  push_ok;
        bit  dv_exp;
        if (mon_on) begin
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("clr_done", clr_done, e_done);
            dv_exp = (dv_due.size() > 0) && (dv_due[0] == cyc);
            if (dv_exp) begin
                e_dd = dv_dat[0];
                void'(dv_due.pop_front());
                void'(dv_dat.pop_front());
            end
            chk("disp_valid", disp_valid, dv_exp);
            chk("disp_data", disp_data, e_dd);
            chk("wr_ready", wr_ready, rst_n && (q_a.size() < 4) && (m_st == 0));
            chk("clr_busy", clr_busy, m_st != 0);
            chk("wr_err", wr_err, m_err);
            if (e_en && !e_we) begin
                dv_due.push_back(cyc + 2);
                dv_dat.push_back(ram[e_addr]);
            end
        end
        if (!rst_n) begin
            q_a.delete(); q_d.delete(); dv_due.delete(); dv_dat.delete();
            m_st = 0; m_cnt = 0; m_col = 0; m_err = 1'b0;
            e_en = 0; e_we = 0; e_done = 0; e_addr = 0; e_wd = 0; e_dd = 0;
            mon_on = 1'b1;
        end else begin
            st      = m_st;
            old_sz  = q_a.size();
            push_ok = wr_valid && (old_sz < 4) && (st == 0);
            e_en = 0; e_we = 0; e_done = 0; e_addr = 0; e_wd = 0;
            if (q_a.size() > 0 && q_a[0] >= DEPTH) begin
                void'(q_a.pop_front());
                void'(q_d.pop_front());
                m_err = 1'b1;
            end
            if (disp_req) begin
                e_en = 1; e_addr = disp_addr;
            end else if (st == 2) begin
                e_en = 1; e_we = 1; e_addr = m_cnt; e_wd = m_col;
                if (m_cnt == DEPTH - 1) begin
                    e_done = 1; m_st = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else if (q_a.size() > 0 && q_a[0] < DEPTH) begin
                e_en = 1; e_we = 1; e_addr = q_a[0]; e_wd = q_d[0];
                void'(q_a.pop_front());
                void'(q_d.pop_front());
            end
            if (st == 0 && clr_start) begin
                m_st = 1; m_col = clr_color;
            end
            if (st == 1 && old_sz == 0) begin
                m_st = 2; m_cnt = 0;
            end
            if (push_ok) begin
                q_a.push_back(wr_addr);
                q_d.push_back(wr_data);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nwr, bad, busy_bad, rdy_bad, ndone, done_k;
        bit done_seen;
        for (int i = 0; i < 65536; i++) ram[i] = '0;
        ram[100] = 3'b101;
        for (int i = 0; i < 21; i++) ram[200 + i] = 3'((i * 3 + 1) % 8);

        // Reset held with traffic requested.
        rst_n = 0; disp_req = 1; disp_addr = 16'd7; wr_valid = 1;
        wr_addr = 16'd1; wr_data = 3'd1; clr_start = 0; clr_color = 3'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_disp_valid", disp_valid, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_clr_busy", clr_busy, 0);
            step();
        end
        rst_n = 1; disp_req = 0; wr_valid = 0;
        @(negedge clk);
        chk("rst_release_wr_ready", wr_ready, 1);
        repeat (2) step();

        // Display latency.
        disp_req = 1; disp_addr = 16'd100; step();
        disp_req = 0;
        @(negedge clk);
        chk("lat_mem_en", mem_en, 1);
        chk("lat_mem_we", mem_we, 0);
        chk("lat_mem_addr", mem_addr, 100);
        step(); @(negedge clk); chk("lat_n2_valid", disp_valid, 0);
        step(); @(negedge clk); chk("lat_n3_valid", disp_valid, 1);
        chk("lat_n3_data", disp_data, 3'b101);
        step(); @(negedge clk); chk("lat_n4_valid", disp_valid, 0);
        chk("lat_hold_data", disp_data, 3'b101);
        repeat (2) step();

        // Contention: reads on even request cycles, four host writes.
        for (int c = 0; c < 21; c++) begin
            disp_req  = (c % 2 == 0) && (c <= 18);
            disp_addr = 16'(200 + c);
            wr_valid  = (c < 4);
            wr_addr   = 16'(c);
            wr_data   = 3'(c + 1);
            @(negedge clk);
            if (c < 4) chk("cont_wr_ready", wr_ready, 1);
            if (c % 2 == 1) begin
                chk("cont_rd_en", mem_en, 1);
                chk("cont_rd_we", mem_we, 0);
                chk("cont_rd_addr", mem_addr, 200 + c - 1);
            end
            if (c >= 2 && c <= 8 && c % 2 == 0) begin
                chk("cont_wr_we", mem_we, 1);
                chk("cont_wr_addr", mem_addr, c / 2 - 1);
                chk("cont_wr_data", mem_wdata, c / 2);
            end
            step();
        end
        wr_valid = 0; disp_req = 0;
        repeat (3) step();

        // FIFO full while the display holds the port.
        k = 0;
        for (int c = 0; c < 22; c++) begin
            disp_req  = (c < 10);
            disp_addr = 16'(400 + c);
            wr_valid  = (k < 6);
            wr_addr   = 16'(300 + k);
            wr_data   = 3'((k + 2) % 8);
            @(negedge clk);
            if (c == 4) chk("full_wr_ready_low", wr_ready, 0);
            if (c == 9) chk("full_accepts_during_disp", k, 4);
            if (c >= 11 && c <= 14) begin
                chk("full_drain_we", mem_we, 1);
                chk("full_drain_addr", mem_addr, 300 + c - 11);
            end
            if (wr_valid && wr_ready) k++;
            step();
        end
        chk("full_total_accepts", k, 6);
        wr_valid = 0; disp_req = 0;
        repeat (3) step();

        // Out-of-range host write, followed by a legal one.
        wr_valid = 1; wr_addr = 16'd28800; wr_data = 3'd7;
        @(negedge clk); chk("oor_err_before", wr_err, 0); step();
        wr_addr = 16'd500; wr_data = 3'd1;
        @(negedge clk); chk("oor_no_access_1", mem_en, 0); step();
        wr_valid = 0;
        @(negedge clk); chk("oor_no_access_2", mem_en, 0); chk("oor_err_set", wr_err, 1); step();
        @(negedge clk); chk("oor_next_addr", mem_addr, 500); step();
        repeat (4) step();
        @(negedge clk); chk("oor_err_sticky", wr_err, 1);
        step();

        // Clear after two host writes.
        wr_valid = 1; wr_addr = 16'd10; wr_data = 3'd6; step();
        wr_addr = 16'd11; wr_data = 3'd7; step();
        wr_valid = 0; clr_start = 1; clr_color = 3'b010;
        @(negedge clk);
        chk("clr_host1_addr", mem_addr, 10); chk("clr_host1_data", mem_wdata, 6);
        step();
        clr_start = 0;
        @(negedge clk);
        chk("clr_host2_addr", mem_addr, 11); chk("clr_host2_data", mem_wdata, 7);
        chk("clr_busy_start", clr_busy, 1); chk("clr_wr_ready_start", wr_ready, 0);
        step();
        nwr = 0; bad = 0; busy_bad = 0; rdy_bad = 0; ndone = 0; done_k = -1; done_seen = 0;
        for (int j = 0; j < DEPTH + 200 && !done_seen; j++) begin
            clr_start = (j == 1000);
            clr_color = (j == 1000) ? 3'd5 : 3'b010;
            @(negedge clk);
            if (mem_en && mem_we) begin
                if (mem_addr !== 16'(nwr) || mem_wdata !== 3'b010) bad++;
                nwr++;
            end
            if (clr_done) begin
                ndone++; done_seen = 1; done_k = j;
            end else begin
                if (!clr_busy) busy_bad++;
                if (wr_ready) rdy_bad++;
            end
            step();
        end
        clr_start = 0;
        repeat (3) begin
            @(negedge clk);
            if (clr_done) ndone++;
            step();
        end
        chk("clr_write_count", nwr, DEPTH);
        chk("clr_order_errors", bad, 0);
        chk("clr_busy_drops", busy_bad, 0);
        chk("clr_wr_ready_highs", rdy_bad, 0);
        chk("clr_done_pulses", ndone, 1);
        chk("clr_done_cycle", done_k, DEPTH);

        // Reset part way through a clear, then restart.
        clr_start = 1; clr_color = 3'd3; step();
        clr_start = 0;
        nwr = 0; ndone = 0;
        for (int j = 0; j < 2000 && nwr < 500; j++) begin
            @(negedge clk);
            if (mem_en && mem_we) nwr++;
            if (clr_done) ndone++;
            step();
        end
        chk("rstclr_writes_before", nwr, 500);
        rst_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (clr_done) ndone++;
            step();
        end
        rst_n = 1;
        @(negedge clk);
        chk("rstclr_idle_busy", clr_busy, 0);
        chk("rstclr_idle_ready", wr_ready, 1);
        chk("rstclr_no_done", ndone, 0);
        clr_start = 1; clr_color = 3'd4; step();
        clr_start = 0;
        nwr = 0; bad = 0;
        for (int j = 0; j < 20 && nwr < 3; j++) begin
            @(negedge clk);
            if (mem_en && mem_we) begin
                chk("restart_addr", mem_addr, nwr);
                chk("restart_data", mem_wdata, 4);
                nwr++;
            end
            step();
        end
        chk("restart_writes_seen", nwr, 3);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
